rr_mux_reg: RTL
===============

RR_MUX_REG -- requirements
Module: rr_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per channel.
REQ-002 SHALL have parameter N, default 8, channel count; legal range 2..16, any value (non-power-of-2 allowed).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  N  per-channel request.
REQ-006 SHALL have port in_data  input  N x WIDTH  per-channel data, channel i in slice i.
REQ-007 SHALL have port in_ready  output  N  per-channel accept, combinational.
REQ-008 SHALL have port out_valid  output  1  output register holds a word.
REQ-009 SHALL have port out_data  output  WIDTH  registered data.
REQ-010 SHALL have port out_sel  output  SELW  source channel of out_data; SELW = $clog2(N).
REQ-011 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-012 SHALL hold a rotating priority pointer ptr (SELW bits); search order ptr, ptr+1, ..., wrapping modulo N (not modulo 2^SELW).
REQ-013 SHALL grant the first valid channel in search order; grant is one-hot or zero.
REQ-014 SHALL drive in_ready[i] = grant[i] AND (NOT out_valid OR out_ready); all in_ready low when no in_valid.
REQ-015 SHALL accept channel k when in_valid[k] AND in_ready[k]; on accept, out_data <= in_data[k], out_sel <= k, out_valid <= 1, ptr <= (k+1) mod N.
REQ-016 SHALL leave ptr unchanged in cycles with no accept.
REQ-017 SHALL implement the output register as two states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on out_ready with accept (back-to-back, one word per cycle sustained).
REQ-018 SHALL hold out_data and out_sel stable while out_valid=1 and out_ready=0.
REQ-019 SHALL have latency of exactly one cycle from accept to out_valid.
REQ-020 SHALL ignore in_data of ungranted channels; in_valid may drop without handshake (no lock).
REQ-021 SHALL, with a single requester, accept it every cycle the output can take data, regardless of ptr.

Reset
REQ-022 SHALL, on rst_n low, immediately set out_valid=0, out_data=0, out_sel=0, ptr=0, and (if enabled) acc_cnt=0, independent of clk.
REQ-023 SHALL drop a word held in the output register when reset asserts mid-transfer; no accept occurs while rst_n is low (in_ready all low).

Configuration
REQ-024 SHALL, with RR_MUX_ACC_CNT_EN defined, add output port acc_cnt (16 bits) counting accepts, saturating at 16'hFFFF, incrementing by one per accept cycle.
REQ-025 SHALL, without RR_MUX_ACC_CNT_EN, have no acc_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-026 SHALL place WIDTH/N defaults, the acc_cnt width constant (16) and the SELW helper in shared package rr_mux_pkg.
REQ-027 SHALL implement grant generation in sub-module rr_arbiter (inputs req[N], ptr; output one-hot grant[N]; combinational); rr_mux_reg holds all state.

Verification
REQ-028 SHALL cover: reset, in_valid=8'hFF, out_ready=1 for 10 cycles -> out_sel sequence 0,1,2,...,7,0,1 with out_data matching in_data[out_sel].
REQ-029 SHALL cover: in_valid=8'b0010_0100, ptr=0, out_ready=1 -> out_sel 2,5,2,5; ptr alternates 3,6.
REQ-030 SHALL cover: out_valid=1, out_ready=0 for 4 cycles with in_valid=8'hFF -> in_ready=0, out_data/out_sel unchanged; out_ready=1 next cycle -> accept same cycle, new word next cycle.
REQ-031 SHALL cover: N=5, in_valid=5'b10001, ptr at 4 after channel 3 accept -> grants 4 then 0 (wrap mod 5, no phantom channels 5..7).
REQ-032 SHALL cover: rst_n pulsed low mid-cycle while FULL -> out_valid, out_data, out_sel, ptr zero before next clk edge; no accept while rst_n low.
REQ-033 SHALL cover (RR_MUX_ACC_CNT_EN): counter preloaded via 65535 accepts -> acc_cnt=16'hFFFF held on further accepts; reset -> 0.

Source files
------------

// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : rr_mux_pkg                                                    |
// | Desc     : Shared defaults, counter width, select-width helper and the   |
// |            output-register state encoding for the round-robin mux.       |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
package rr_mux_pkg;

  localparam int RR_WIDTH_DEF = 16;
  localparam int RR_N_DEF     = 8;
  localparam int ACC_CNT_W    = 16;

  // Width of a channel index; a lone channel still needs one bit of select.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_mux_reg_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : rr_arbiter                                                    |
// | Desc     : Combinational rotating-priority arbiter. Searches ptr, ptr+1, |
// |            ... wrapping modulo N and grants the first requester.         |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N = RR_N_DEF
) (
  input  logic [N-1:0]        req,
  input  logic [sel_w(N)-1:0] ptr,
  output logic [N-1:0]        grant
);

  localparam int SELW = sel_w(N);
  // N expressed one bit wider than a select so ptr+offset never overflows.
  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

  logic [SELW:0]   sum;
  logic [SELW-1:0] idx;
  logic            found;

  // Walk the search order once; the wrap is modulo N so no phantom channels.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int o = 0; o < N; o++) begin
      sum = {1'b0, ptr} + (SELW+1)'(o);
      if (sum >= N_EXT) begin
        sum = sum - N_EXT;
      end
      idx = sum[SELW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : rr_mux_reg                                                    |
// | Desc     : N-channel round-robin multiplexer into a single output        |
// |            register with valid/ready handshakes on both sides.           |
// |            Optional accept counter: define RR_MUX_ACC_CNT_EN.            |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = RR_WIDTH_DEF,
  parameter int N     = RR_N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          in_valid,
  input  logic [N*WIDTH-1:0]    in_data,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [sel_w(N)-1:0]   out_sel,
  input  logic                  out_ready
`ifdef RR_MUX_ACC_CNT_EN
  ,
  output logic [ACC_CNT_W-1:0]  acc_cnt
`endif
);

  localparam int SELW = sel_w(N);

  out_state_t       state;
  logic [SELW-1:0]  ptr;
  logic [N-1:0]     grant;
  logic             out_free;
  logic             accept;
  logic [SELW-1:0]  gsel;
  logic [WIDTH-1:0] gdata;
  logic [SELW-1:0]  ptr_next;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign out_valid = (state == ST_FULL);
  assign out_free  = !out_valid || out_ready;
  // Reset gating keeps every channel stalled while rst_n is held low.
  assign in_ready  = (rst_n && out_free) ? grant : '0;
  assign accept    = |in_ready;
  assign ptr_next  = (gsel == SELW'(N-1)) ? '0 : gsel + SELW'(1);

  // Encode the one-hot grant and steer the granted channel's data.
  always_comb begin
    gsel  = '0;
    gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gsel  = SELW'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register state machine; an accept always wins over a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state    <= ST_FULL;
            out_data <= gdata;
            out_sel  <= gsel;
            ptr      <= ptr_next;
          end
        end
        ST_FULL: begin
          if (accept) begin
            out_data <= gdata;
            out_sel  <= gsel;
            ptr      <= ptr_next;
          end else if (out_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef RR_MUX_ACC_CNT_EN
  // Saturating count of accepted words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (accept && (acc_cnt != '1)) begin
      acc_cnt <= acc_cnt + ACC_CNT_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire
